// File: rtl/qrisc_ex_iter_if.sv
// qrisc_ex_iter_if: operation/result bus between decode, the execute stage
// and the memory stage.
//
// Handshake: an operation is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready is a function of the stage state and
// pipe_stall only, never of in_valid. A producer that sees in_ready low must
// hold op and operands stable with in_valid high until it is taken. On the
// result side there is no back-pressure: out_valid and new_address_valid
// are single-cycle pulses, and pipe_stall keeps the result registers frozen.
interface qrisc_ex_iter_if #(
    parameter int XLEN   = 32,
    parameter int INCR_W = 4
);
    logic              pipe_stall;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [XLEN-1:0]   val_r1;
    logic [XLEN-1:0]   val_r2;
    logic [INCR_W-1:0] incr_r2;
    logic              incr_r2_en;
    logic              out_valid;
    logic [XLEN-1:0]   val_dst;
    logic [XLEN-1:0]   val_r2_out;
    logic              flag_z;
    logic              flag_c;
    logic              busy;
    logic              new_address_valid;
    logic [XLEN-1:0]   new_address;
    logic [1:0]        dbg_state;

    modport master (
        output pipe_stall, in_valid, op, val_r1, val_r2, incr_r2, incr_r2_en,
        input  in_ready, out_valid, val_dst, val_r2_out, flag_z, flag_c, busy,
        input  new_address_valid, new_address, dbg_state
    );

    modport slave (
        input  pipe_stall, in_valid, op, val_r1, val_r2, incr_r2, incr_r2_en,
        output in_ready, out_valid, val_dst, val_r2_out, flag_z, flag_c, busy,
        output new_address_valid, new_address, dbg_state
    );
endinterface

// File: rtl/qrisc_ex_iter.sv
// qrisc_ex_iter: Qrisc execute stage. Single-cycle ALU, jump and address
// operations, an iterative shift-add multiplier retiring MUL_BITS multiplier
// bits per cycle, and Z/C flag state.
// Optional feature macro: QRISC_EX_DIV_EN adds an unsigned restoring divider
// on op 14; without it op 14 is a NOP.
module qrisc_ex_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1,
    parameter int INCR_W   = 4
) (
    input logic            clk,
    input logic            reset,
    qrisc_ex_iter_if.slave io_bus
);
    localparam int N_MUL = XLEN / MUL_BITS;
    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JZ  = 4'd10;
    localparam logic [3:0] OP_JNZ = 4'd11;
    localparam logic [3:0] OP_JC  = 4'd12;
    localparam logic [3:0] OP_JNC = 4'd13;
    localparam logic [3:0] OP_MEM = 4'd15;

`ifdef QRISC_EX_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd14;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd3} state_t;
`endif

    state_t           r_state;
    logic [XLEN-1:0]  r_val_dst;
    logic [XLEN-1:0]  r_val_r2_out;
    logic [XLEN-1:0]  r_new_address;
    logic             r_out_valid;
    logic             r_new_address_valid;
    logic             r_flag_z;
    logic             r_flag_c;
    // Shared iteration registers: multiplicand/divisor, multiplier/quotient
    // shift register, and upper product half/partial remainder.
    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  r_hi;
    logic [CNT_W-1:0] r_cnt;
`ifdef QRISC_EX_DIV_EN
    logic             r_is_div;
    logic             r_div0;
    logic [XLEN:0]    w_dshift;
    logic             w_dge;
    logic [XLEN-1:0]  w_drem;
`endif

    logic                     w_in_ready;
    logic                     w_accept;
    logic [XLEN:0]            w_add;
    logic [XLEN:0]            w_shl;
    logic [XLEN:0]            w_shr;
    logic [XLEN-1:0]          w_r2_next;
    logic [MUL_BITS-1:0]      w_digit;
    logic [XLEN+MUL_BITS-1:0] w_pp;
    logic [XLEN+MUL_BITS-1:0] w_msum;
    logic [XLEN-1:0]          w_lo_next;
    logic [XLEN-1:0]          w_sc_dst;
    logic                     w_sc_out;
    logic                     w_sc_wr_flags;
    logic                     w_sc_z;
    logic                     w_sc_c;
    logic                     w_is_jump;
    logic                     w_taken;

    assign w_in_ready = (r_state == ST_IDLE) && !io_bus.pipe_stall;
    assign w_accept   = io_bus.in_valid && w_in_ready;

    assign w_add     = {1'b0, io_bus.val_r1} + {1'b0, io_bus.val_r2};
    assign w_shl     = {1'b0, io_bus.val_r1} << io_bus.val_r2;
    assign w_shr     = {io_bus.val_r1, 1'b0} >> io_bus.val_r2;
    assign w_r2_next = io_bus.incr_r2_en
                     ? io_bus.val_r2 + {{(XLEN-INCR_W){io_bus.incr_r2[INCR_W-1]}}, io_bus.incr_r2}
                     : io_bus.val_r2;

    // One multiplier step: add multiplicand*digit to the upper half, then
    // shift the whole {hi, lo} pair right by MUL_BITS.
    assign w_digit   = r_mplier[MUL_BITS-1:0];
    assign w_pp      = {{MUL_BITS{1'b0}}, r_mcand} * {{XLEN{1'b0}}, w_digit};
    assign w_msum    = {{MUL_BITS{1'b0}}, r_hi} + w_pp;
    assign w_lo_next = XLEN'({w_msum[MUL_BITS-1:0], r_mplier} >> MUL_BITS);

`ifdef QRISC_EX_DIV_EN
    // One restoring-divide step: shift the next dividend bit into the
    // remainder and subtract the divisor when it fits.
    assign w_dshift = {r_hi, r_mplier[XLEN-1]};
    assign w_dge    = w_dshift >= {1'b0, r_mcand};
    assign w_drem   = w_dge ? XLEN'(w_dshift - {1'b0, r_mcand}) : XLEN'(w_dshift);
`endif

    assign io_bus.in_ready          = w_in_ready;
    assign io_bus.out_valid         = r_out_valid;
    assign io_bus.val_dst           = r_val_dst;
    assign io_bus.val_r2_out        = r_val_r2_out;
    assign io_bus.flag_z            = r_flag_z;
    assign io_bus.flag_c            = r_flag_c;
    assign io_bus.busy              = (r_state != ST_IDLE);
    assign io_bus.new_address_valid = r_new_address_valid;
    assign io_bus.new_address       = r_new_address;
    assign io_bus.dbg_state         = r_state;

    // Decode of the single-cycle operations: result, flag values, jump decision.
    always_comb begin
        w_sc_dst      = r_val_dst;
        w_sc_out      = 1'b1;
        w_sc_wr_flags = 1'b0;
        w_sc_c        = r_flag_c;
        w_is_jump     = 1'b0;
        w_taken       = 1'b0;
        case (io_bus.op)
            OP_AND: begin w_sc_dst = io_bus.val_r1 & io_bus.val_r2; w_sc_wr_flags = 1'b1; w_sc_c = 1'b0; end
            OP_OR:  begin w_sc_dst = io_bus.val_r1 | io_bus.val_r2; w_sc_wr_flags = 1'b1; w_sc_c = 1'b0; end
            OP_XOR: begin w_sc_dst = io_bus.val_r1 ^ io_bus.val_r2; w_sc_wr_flags = 1'b1; w_sc_c = 1'b0; end
            OP_ADD: begin w_sc_dst = w_add[XLEN-1:0]; w_sc_wr_flags = 1'b1; w_sc_c = w_add[XLEN]; end
            OP_SHL: begin w_sc_dst = w_shl[XLEN-1:0]; w_sc_wr_flags = 1'b1; w_sc_c = w_shl[XLEN]; end
            OP_SHR: begin w_sc_dst = w_shr[XLEN:1];   w_sc_wr_flags = 1'b1; w_sc_c = w_shr[0]; end
            OP_CMP: begin w_sc_wr_flags = 1'b1; w_sc_c = (io_bus.val_r1 < io_bus.val_r2); end
            OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
                w_sc_dst  = w_add[XLEN-1:0];
                w_is_jump = 1'b1;
                case (io_bus.op)
                    OP_JZ:   w_taken = r_flag_z;
                    OP_JNZ:  w_taken = !r_flag_z;
                    OP_JC:   w_taken = r_flag_c;
                    OP_JNC:  w_taken = !r_flag_c;
                    default: w_taken = 1'b1;
                endcase
            end
            OP_MEM:  w_sc_dst = w_add[XLEN-1:0];
            default: w_sc_out = 1'b0;
        endcase
        w_sc_z = (io_bus.op == OP_CMP) ? (io_bus.val_r1 == io_bus.val_r2) : (w_sc_dst == '0);
    end

    // Stage FSM and all output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= ST_IDLE;
            r_val_dst           <= '0;
            r_val_r2_out        <= '0;
            r_new_address       <= '0;
            r_out_valid         <= 1'b0;
            r_new_address_valid <= 1'b0;
            r_flag_z            <= 1'b0;
            r_flag_c            <= 1'b0;
            r_mcand             <= '0;
            r_mplier            <= '0;
            r_hi                <= '0;
            r_cnt               <= '0;
`ifdef QRISC_EX_DIV_EN
            r_is_div            <= 1'b0;
            r_div0              <= 1'b0;
`endif
        end else begin
            r_out_valid         <= 1'b0;
            r_new_address_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef QRISC_EX_DIV_EN
                        if (io_bus.op != OP_DIV) r_val_r2_out <= w_r2_next;
`else
                        r_val_r2_out <= w_r2_next;
`endif
                        if (w_sc_out) begin
                            r_out_valid <= 1'b1;
                            r_val_dst   <= w_sc_dst;
                            if (w_sc_wr_flags) begin
                                r_flag_z <= w_sc_z;
                                r_flag_c <= w_sc_c;
                            end
                            if (w_is_jump) begin
                                r_new_address       <= w_sc_dst;
                                r_new_address_valid <= w_taken;
                            end
                        end
                        if (io_bus.op == OP_MUL) begin
                            r_state  <= ST_MUL;
                            r_mcand  <= io_bus.val_r1;
                            r_mplier <= io_bus.val_r2;
                            r_hi     <= '0;
                            r_cnt    <= CNT_W'(N_MUL);
`ifdef QRISC_EX_DIV_EN
                            r_is_div <= 1'b0;
`endif
                        end
`ifdef QRISC_EX_DIV_EN
                        if (io_bus.op == OP_DIV) begin
                            r_state  <= ST_DIV;
                            r_mcand  <= io_bus.val_r2;
                            r_mplier <= io_bus.val_r1;
                            r_hi     <= '0;
                            r_cnt    <= CNT_W'(XLEN);
                            r_is_div <= 1'b1;
                            r_div0   <= (io_bus.val_r2 == '0);
                        end
`endif
                    end
                end
                ST_MUL: begin
                    r_hi     <= w_msum[XLEN+MUL_BITS-1:MUL_BITS];
                    r_mplier <= w_lo_next;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= ST_DONE;
                end
`ifdef QRISC_EX_DIV_EN
                ST_DIV: begin
                    r_hi     <= w_drem;
                    r_mplier <= {r_mplier[XLEN-2:0], w_dge};
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (!io_bus.pipe_stall) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b1;
                        r_val_dst   <= r_mplier;
                        r_flag_z    <= (r_mplier == '0);
`ifdef QRISC_EX_DIV_EN
                        if (r_is_div) begin
                            r_val_r2_out <= r_hi;
                            r_flag_c     <= r_div0;
                        end else begin
                            r_val_dst    <= r_mplier;
                            r_flag_c     <= r_hi[0];
                        end
`else
                        r_flag_c    <= r_hi[0];
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qrisc_ex_iter.sv
// tb_qrisc_ex_iter: directed vectors for qrisc_ex_iter (XLEN=32, MUL_BITS=4).
// Expected results are pushed when an operation is issued; a monitor pops
// and compares whenever the stage presents out_valid or a jump request.
module tb_qrisc_ex_iter;
    localparam int XLEN = 32;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JZ  = 4'd10;
    localparam logic [3:0] OP_JNZ = 4'd11;
    localparam logic [3:0] OP_JC  = 4'd12;
    localparam logic [3:0] OP_JNC = 4'd13;
    localparam logic [3:0] OP_DIV = 4'd14;
    localparam logic [3:0] OP_MEM = 4'd15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qrisc_ex_iter_if #(.XLEN(XLEN), .INCR_W(4)) bus ();

    qrisc_ex_iter #(.XLEN(XLEN), .MUL_BITS(4), .INCR_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [65:0] exp_q[$];   // {val_dst, val_r2_out, flag_z, flag_c}
    logic [31:0] exp_jq[$];  // expected jump targets
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] dst, input logic [31:0] r2o, input logic z, input logic c);
        exp_q.push_back({dst, r2o, z, c});
    endtask

    task automatic monitor();
        logic [65:0] e;
        logic [31:0] ja;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_out_valid: got val_dst=0x%0h, expected no result (t=%0t)", bus.val_dst, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 96'({bus.val_dst, bus.val_r2_out, bus.flag_z, bus.flag_c}), 96'(e));
                    end
                end
                if (bus.new_address_valid) begin
                    if (exp_jq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_jump: got new_address=0x%0h, expected no jump (t=%0t)", bus.new_address, $time);
                    end else begin
                        ja = exp_jq.pop_front();
                        check("jump_target", 96'(bus.new_address), 96'(ja));
                    end
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [3:0] inc, input logic inc_en);
        int budget;
        bus.op         = op;
        bus.val_r1     = r1;
        bus.val_r2     = r2;
        bus.incr_r2    = inc;
        bus.incr_r2_en = inc_en;
        bus.in_valid   = 1'b1;
        budget = 0;
        while (!bus.in_ready && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", budget);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = OP_NOP;
    endtask

    task automatic wait_result(input string name, input int req_cyc);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(name, 96'(cyc), 96'(req_cyc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        time t0;
        bus.pipe_stall = 1'b0;
        bus.in_valid   = 1'b0;
        bus.op         = OP_NOP;
        bus.val_r1     = '0;
        bus.val_r2     = '0;
        bus.incr_r2    = '0;
        bus.incr_r2_en = 1'b0;
        reset = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 96'(bus.out_valid), 96'(0));
        check("rst_val_dst", 96'(bus.val_dst), 96'(0));
        check("rst_val_r2_out", 96'(bus.val_r2_out), 96'(0));
        check("rst_flags", 96'({bus.flag_z, bus.flag_c}), 96'(0));
        check("rst_busy", 96'(bus.busy), 96'(0));
        check("rst_jump", 96'({bus.new_address_valid, bus.new_address}), 96'(0));
        check("rst_state", 96'(bus.dbg_state), 96'(0));
        check("rst_in_ready", 96'(bus.in_ready), 96'(1));
        bus.pipe_stall = 1'b1;
        #1;
        check("stall_in_ready", 96'(bus.in_ready), 96'(0));
        bus.pipe_stall = 1'b0;
        #1;

        // Single-cycle ALU ops
        push_exp(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 4'h0, 1'b0);
        check("add_out_valid", 96'(bus.out_valid), 96'(1));
        push_exp(32'h0000_00F0, 32'h0000_0FEF, 1'b0, 1'b0);
        issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 4'hF, 1'b1);
        push_exp(32'h0000_FFFF, 32'h0000_FF03, 1'b0, 1'b0);
        issue(OP_OR, 32'h0000_00FF, 32'h0000_FF00, 4'h3, 1'b1);
        push_exp(32'h0000_0000, 32'h0000_1234, 1'b1, 1'b0);
        issue(OP_XOR, 32'h0000_1234, 32'h0000_1234, 4'h0, 1'b0);
        push_exp(32'h0000_0002, 32'h0000_0001, 1'b0, 1'b1);
        issue(OP_SHL, 32'h8000_0001, 32'h0000_0001, 4'h0, 1'b0);
        push_exp(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
        issue(OP_SHR, 32'h0000_0003, 32'h0000_0001, 4'h0, 1'b0);
        push_exp(32'h0000_0000, 32'h0000_0020, 1'b1, 1'b1);
        issue(OP_SHL, 32'h0000_0001, 32'h0000_0020, 4'h0, 1'b0);
        push_exp(32'h0000_0000, 32'h0000_0007, 1'b0, 1'b1);
        issue(OP_CMP, 32'h0000_0005, 32'h0000_0007, 4'h0, 1'b0);

        // Jumps and address generation
        push_exp(32'h0000_0120, 32'h0000_0020, 1'b0, 1'b1);
        exp_jq.push_back(32'h0000_0120);
        issue(OP_JC, 32'h0000_0100, 32'h0000_0020, 4'h0, 1'b0);
        check("jc_pulse", 96'(bus.new_address_valid), 96'(1));
        push_exp(32'h0000_0120, 32'h0000_0020, 1'b0, 1'b1);
        issue(OP_JNC, 32'h0000_0100, 32'h0000_0020, 4'h0, 1'b0);
        check("jnc_no_pulse", 96'(bus.new_address_valid), 96'(0));
        push_exp(32'h0000_1024, 32'h0000_0026, 1'b0, 1'b1);
        issue(OP_MEM, 32'h0000_1000, 32'h0000_0024, 4'h2, 1'b1);
        push_exp(32'h0000_0044, 32'h0000_0004, 1'b0, 1'b1);
        issue(OP_JZ, 32'h0000_0040, 32'h0000_0004, 4'h0, 1'b0);
        check("jz_no_pulse", 96'(bus.new_address_valid), 96'(0));
        push_exp(32'h0000_0044, 32'h0000_0004, 1'b0, 1'b1);
        exp_jq.push_back(32'h0000_0044);
        issue(OP_JNZ, 32'h0000_0040, 32'h0000_0004, 4'h0, 1'b0);
        check("jnz_pulse", 96'(bus.new_address_valid), 96'(1));
        push_exp(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
        exp_jq.push_back(32'h0000_0010);
        issue(OP_JMP, 32'hFFFF_FFF0, 32'h0000_0020, 4'h0, 1'b0);
        check("jmp_pulse", 96'(bus.new_address_valid), 96'(1));
        issue(OP_NOP, 32'h0000_0055, 32'h0000_0066, 4'h0, 1'b0);
        check("nop_no_out", 96'({bus.out_valid, bus.new_address_valid}), 96'(0));

        // MUL: 0x10000 * 0x10000 = 2^32
        push_exp(32'h0000_0000, 32'h0001_0000, 1'b1, 1'b1);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'h0, 1'b0);
        check("mul_busy", 96'({bus.busy, bus.in_ready}), 96'(2'b10));
        wait_result("mul_latency", 9);

        // MUL with downstream stall across completion
        push_exp(32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 1'b1);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 4'h0, 1'b0);
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) bus.pipe_stall = 1'b1;
            if (cyc == 10) check("mul_done_wait", 96'({bus.busy, bus.in_ready, bus.out_valid}), 96'(3'b100));
            if (cyc == 12) bus.pipe_stall = 1'b0;
        end
        bus.pipe_stall = 1'b0;
        check("mul_stall_latency", 96'(cyc), 96'(13));

        // Reset in the middle of a multiply
        issue(OP_MUL, 32'h0000_0003, 32'h0000_0005, 4'h0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_regs", 96'({bus.val_dst, bus.val_r2_out}), 96'(0));
        check("midrst_flags", 96'({bus.flag_z, bus.flag_c, bus.out_valid}), 96'(0));
        check("midrst_ready", 96'({bus.in_ready, bus.busy}), 96'(2'b10));
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("midrst_no_result", 96'(bus.val_dst), 96'(0));

        // Back-to-back single-cycle ops; JZ sees Z written by the XOR just before
        t0 = $time;
        push_exp(32'h0000_000F, 32'h0000_0008, 1'b0, 1'b0);
        issue(OP_ADD, 32'h0000_0007, 32'h0000_0008, 4'h0, 1'b0);
        push_exp(32'h0000_0000, 32'h0000_000F, 1'b1, 1'b0);
        issue(OP_XOR, 32'h0000_000F, 32'h0000_000F, 4'h0, 1'b0);
        push_exp(32'h0000_0011, 32'h0000_0001, 1'b1, 1'b0);
        exp_jq.push_back(32'h0000_0011);
        issue(OP_JZ, 32'h0000_0010, 32'h0000_0001, 4'h0, 1'b0);
        check("b2b_cycles", 96'(($time - t0) / 10), 96'(3));
        check("jz_pulse", 96'(bus.new_address_valid), 96'(1));

        // MUL 123 * 45 = 5535
        push_exp(32'h0000_159F, 32'h0000_002D, 1'b0, 1'b0);
        issue(OP_MUL, 32'd123, 32'd45, 4'h0, 1'b0);
        wait_result("mul2_latency", 9);

`ifdef QRISC_EX_DIV_EN
        // DIV 100/7 = 14 r 2 (increment suppressed); DIV 5/0
        push_exp(32'd14, 32'd2, 1'b0, 1'b0);
        issue(OP_DIV, 32'd100, 32'd7, 4'h1, 1'b1);
        wait_result("div_latency", 33);
        push_exp(32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1);
        issue(OP_DIV, 32'd5, 32'd0, 4'h0, 1'b0);
        wait_result("div0_latency", 33);
`else
        // Without the divider op 14 is a NOP
        issue(OP_DIV, 32'd100, 32'd7, 4'h0, 1'b0);
        check("div_as_nop", 96'({bus.busy, bus.in_ready, bus.out_valid}), 96'(3'b010));
`endif

        repeat (5) begin
            @(posedge clk); #1;
        end
        check("exp_q_drained", 96'(exp_q.size()), 96'(0));
        check("exp_jq_drained", 96'(exp_jq.size()), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/qrisc_ex_iter.md
# qrisc_ex_iter

Parametrised execute stage for the Qrisc core family. It sits between decode and memory stages and performs single-cycle ALU and address operations. It adds an iterative multi-cycle multiplier, and an optional divider, behind a valid/ready handshake. It keeps the Z/C flag state and raises jump requests toward the memory stage.

## Interface
- `XLEN`, 32: datapath width; 8..64, multiple of `MUL_BITS`.
- `MUL_BITS`, 1: multiplier bits retired per cycle; 1, 2, 4 or 8.
- `INCR_W`, 4: width of the signed post-increment field.
- `clk` in 1: clock. Single clock domain; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pipe_stall` in 1: downstream stall; holds the output registers.
- `in_valid` in 1: the operation on the input bus is valid.
- `in_ready` out 1: the stage can accept an operation this cycle.
- `op` in 4: operation code. 0 NOP, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 MUL, 6 SHL, 7 SHR, 8 CMP, 9 JMP, 10 JZ, 11 JNZ, 12 JC, 13 JNC, 14 DIV, 15 MEM.
- `val_r1`, `val_r2` in XLEN: operands.
- `incr_r2` in INCR_W: signed post-increment for r2.
- `incr_r2_en` in 1: enables the r2 post-increment.
- `out_valid` out 1: the result registers hold a new result.
- `val_dst` out XLEN: result, or memory address for MEM.
- `val_r2_out` out XLEN: r2, post-incremented when enabled.
- `flag_z`, `flag_c` out 1: architectural flags.
- `busy` out 1: a multi-cycle operation is in progress.
- `new_address_valid` out 1: one-cycle jump request.
- `new_address` out XLEN: jump target.

## Operation
- Accept rule: an operation is accepted when `in_valid && in_ready`. `in_ready = (state==IDLE) && !pipe_stall`.
- Single-cycle ops (1-4, 6-13, 15) go to the output registers on the accept edge.
- Results per op:
  - ADD: `{C,dst} = r1+r2` on XLEN+1 bits.
  - AND/OR/XOR: C=0.
  - SHL: `{C,dst} = r1<<r2`.
  - SHR: `{dst,C} = {r1,0}>>r2`.
  - CMP: no dst write, `Z = (r1==r2)`, `C = (r1<r2)` unsigned.
  - Z is set when dst==0 for every flag-writing op.
- Flag writers: AND, OR, XOR, ADD, MUL, SHL, SHR, CMP, DIV. All other ops leave the flags unchanged.
- Jumps (9-13):
  - Target is `(r1+r2) mod 2^XLEN`, written to `val_dst` and `new_address`.
  - Taken condition: JMP always; JZ Z; JNZ !Z; JC C; JNC !C. The condition uses the flags as they stand at the accept edge.
  - When taken, `new_address_valid` pulses for exactly one cycle.
- MEM: `val_dst = r1+r2` (address); flags unchanged.
- `val_r2_out = incr_r2_en ? r2 + sext(incr_r2) : r2`, for every op.
- The FSM has four states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL: on accepting op 5.
  - IDLE→DIV: on accepting op 14.
  - MUL→DONE: after `XLEN/MUL_BITS` iterations.
  - DIV→DONE: after XLEN iterations.
  - DONE→IDLE: when `!pipe_stall`, writing the result, the flags and `out_valid`.
- MUL: shift-add, unsigned, full 2·XLEN product. `dst` = low XLEN bits. `C = product[XLEN]`.
- `busy` is high in MUL, DIV and DONE.
- `out_valid` is high for one cycle per written result. It stays low on stall cycles, with the registers holding.
- NOP is accepted and produces no `out_valid`.

## Timing
- Reset values: every output register is 0, flags are 0, state is IDLE. After reset, `in_ready` = `!pipe_stall`.
- Single-cycle op: accepted at edge k. `out_valid` and the result are visible after edge k; the flags are visible after edge k.
- MUL: accepted at edge k. The result is visible after edge k+N+1, with N = XLEN/MUL_BITS. Any stall at DONE adds one cycle per stalled cycle.
- DIV: latency XLEN+1 cycles under the same rule.
- Back-to-back single-cycle ops are accepted every cycle; throughput is 1.
- A stall during MUL/DIV does not pause the iteration. The completed result waits in DONE.
- Reset mid-operation: the iteration is aborted, no result is written, state returns to IDLE.
- `in_valid` while `in_ready` is low: the operation is not accepted, and the producer must hold it.
- Stall during a single-cycle accept cannot occur, because `in_ready` is low while `pipe_stall` is high.

## Configuration
- `QRISC_EX_DIV_EN`:
  - Defined: op 14 is an unsigned restoring divide. `dst` = quotient, `val_r2_out` = remainder; the r2 post-increment is suppressed for DIV. Z is set when quotient==0. Divide-by-zero gives quotient all-ones, remainder r1, C=1; otherwise C=0.
  - Undefined: op 14 behaves as NOP, the DIV state is absent, and `busy` is never set by op 14.

## Test plan
- XLEN=32: ADD r1=0xFFFFFFFF, r2=1 → next cycle val_dst=0, Z=1, C=1, out_valid=1.
- MUL_BITS=4: MUL r1=0x10000, r2=0x10000 → in_ready low 9 cycles; val_dst=0, C=1, Z=1 after edge 9.
- CMP 5,7 then JC r1=0x100, r2=0x20 → new_address_valid one-cycle pulse, new_address=0x120. Same with JNC → no pulse.
- MUL accepted, pipe_stall held high cycles 3-12 → result after the edge where the stall drops, exactly one out_valid.
- Reset asserted at iteration 4 of MUL → outputs 0, flags 0, in_ready=1 the next cycle, no out_valid.
- With `QRISC_EX_DIV_EN`: DIV 100/7 → quotient 14, remainder 2 after 33 cycles. DIV 5/0 → 0xFFFFFFFF, C=1.
